// File: rtl/soc_system_mailbox_engine_if.sv
// rtl/soc_system_mailbox_engine_if.sv - Avalon-MM port s2 bundle between the mailbox engine and the shared RAM
interface soc_system_mailbox_engine_if;
  logic [1:0]  address2;
  logic        chipselect2;
  logic        write2;
  logic [3:0]  byteenable2;
  logic [31:0] writedata2;
  logic        clken2;
  logic [31:0] readdata2;

  modport master (
    output address2, chipselect2, write2, byteenable2, writedata2, clken2,
    input  readdata2
  );

  modport slave (
    input  address2, chipselect2, write2, byteenable2, writedata2, clken2,
    output readdata2
  );
endinterface

// File: rtl/soc_system_mailbox_engine.sv
// rtl/soc_system_mailbox_engine.sv - polls the shared-RAM mailbox, runs one ALU command, posts result/status
// Optional multiply opcode enabled by MAILBOX_MUL_EN.
module soc_system_mailbox_engine #(
  parameter int unsigned POLL_INTERVAL = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  soc_system_mailbox_engine_if.master   bus,
  output logic                          busy,
  output logic                          irq
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_CMD, S_CAP_CMD, S_RD_A, S_RD_B, S_EXEC, S_WR_RES, S_WR_STAT, S_CLR_GO
  } state_t;

  localparam logic [15:0] POLL_LOAD = 16'(POLL_INTERVAL - 1);

  state_t      state_q;
  logic [15:0] poll_cnt_q;
  logic [1:0]  addr_q;
  logic        cs_q;
  logic        wr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        busy_q;
  logic        irq_q;
  logic [7:0]  seq_q;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] alu_d;
  logic        op_legal;

  function automatic logic [31:0] status_word(input logic [3:0] op, input logic [7:0] seq,
                                              input logic err);
    return {12'h000, op, seq, 6'h00, err, 1'b1};
  endfunction

  // B is consumed straight off readdata2 in EXEC; only the registered result leaves the block.
  always_comb begin
    alu_d    = '0;
    op_legal = 1'b1;
    case (op_q)
      4'd0: alu_d = a_q + bus.readdata2;
      4'd1: alu_d = a_q - bus.readdata2;
      4'd2: alu_d = a_q & bus.readdata2;
      4'd3: alu_d = a_q | bus.readdata2;
      4'd4: alu_d = a_q ^ bus.readdata2;
`ifdef MAILBOX_MUL_EN
      4'd5: alu_d = a_q * bus.readdata2;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      poll_cnt_q <= POLL_LOAD;
      addr_q     <= 2'd0;
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      be_q       <= 4'hF;
      wdata_q    <= 32'h0;
      busy_q     <= 1'b0;
      irq_q      <= 1'b0;
      seq_q      <= 8'h00;
      op_q       <= 4'h0;
      a_q        <= 32'h0;
    end else begin
      // Bus outputs describe the state being entered, so defaults are the idle bus.
      irq_q <= 1'b0;
      cs_q  <= 1'b0;
      wr_q  <= 1'b0;
      be_q  <= 4'hF;
      case (state_q)
        S_IDLE: begin
          if (poll_cnt_q == 16'd0) begin
            state_q <= S_RD_CMD;
            cs_q    <= 1'b1;
            addr_q  <= 2'd0;
          end else begin
            poll_cnt_q <= poll_cnt_q - 16'd1;
          end
        end
        S_RD_CMD: state_q <= S_CAP_CMD;
        S_CAP_CMD: begin
          if (bus.readdata2[31]) begin
            op_q    <= bus.readdata2[3:0];
            busy_q  <= 1'b1;
            state_q <= S_RD_A;
            cs_q    <= 1'b1;
            addr_q  <= 2'd1;
          end else begin
            state_q    <= S_IDLE;
            poll_cnt_q <= POLL_LOAD;
          end
        end
        S_RD_A: begin
          state_q <= S_RD_B;
          cs_q    <= 1'b1;
          addr_q  <= 2'd2;
        end
        S_RD_B: begin
          a_q     <= bus.readdata2;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          cs_q <= 1'b1;
          wr_q <= 1'b1;
          if (op_legal) begin
            state_q <= S_WR_RES;
            addr_q  <= 2'd2;
            wdata_q <= alu_d;
          end else begin
            state_q <= S_WR_STAT;
            addr_q  <= 2'd3;
            wdata_q <= status_word(op_q, seq_q + 8'd1, 1'b1);
          end
        end
        S_WR_RES: begin
          state_q <= S_WR_STAT;
          cs_q    <= 1'b1;
          wr_q    <= 1'b1;
          addr_q  <= 2'd3;
          wdata_q <= status_word(op_q, seq_q + 8'd1, 1'b0);
        end
        S_WR_STAT: begin
          seq_q   <= seq_q + 8'd1;
          state_q <= S_CLR_GO;
          cs_q    <= 1'b1;
          wr_q    <= 1'b1;
          addr_q  <= 2'd0;
          be_q    <= 4'b1000;
          wdata_q <= 32'h0;
        end
        S_CLR_GO: begin
          state_q    <= S_IDLE;
          poll_cnt_q <= POLL_LOAD;
          busy_q     <= 1'b0;
          irq_q      <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.address2    = addr_q;
  assign bus.chipselect2 = cs_q;
  assign bus.write2      = wr_q;
  assign bus.byteenable2 = be_q;
  assign bus.writedata2  = wdata_q;
  assign bus.clken2      = 1'b1;
  assign busy            = busy_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_soc_system_mailbox_engine.sv
// tb/tb_soc_system_mailbox_engine.sv - scoreboard bench for the mailbox engine against a 4-word dual-port RAM
module tb_soc_system_mailbox_engine;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy, irq;
  always #5 clk = ~clk;

  soc_system_mailbox_engine_if bus ();

  soc_system_mailbox_engine #(.POLL_INTERVAL(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy),
    .irq     (irq)
  );

  logic [31:0] mem [4] = '{default: 32'h0};
  logic        hps_we = 1'b0;
  logic [1:0]  hps_addr = 2'd0;
  logic [31:0] hps_data = 32'h0;

  // HPS side (s1) and engine side (s2) of the shared RAM.
  always @(posedge clk) begin
    if (hps_we) mem[hps_addr] <= hps_data;
    if (bus.chipselect2 && bus.clken2) begin
      if (bus.write2) begin
        for (int l = 0; l < 4; l++)
          if (bus.byteenable2[l]) mem[bus.address2][l*8 +: 8] <= bus.writedata2[l*8 +: 8];
      end else begin
        bus.readdata2 <= mem[bus.address2];
      end
    end
  end

  typedef struct {
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
    int          off;
  } wr_t;

  wr_t exp_q[$];
  int  irq_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  last_rd = 0;
  int  irq_seen = 0;
  bit  prev_valid = 0;
  bit  check_poll = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: offsets are measured from the most recent command-word read (cycle C-1).
  always @(negedge clk) begin
    cyc++;
    if (bus.chipselect2 && !bus.write2 && bus.address2 == 2'd0) begin
      if (check_poll && prev_valid) begin
        chk("poll_period", 32'(cyc - last_rd), 32'd6);
        chk("poll_busy_irq", {30'h0, busy, irq}, 32'h0);
      end
      prev_valid = check_poll;
      last_rd = cyc;
    end
    if (bus.chipselect2 && bus.write2) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {30'h0, bus.address2}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {30'h0, bus.address2}, {30'h0, e.addr});
        chk("wr_be", {28'h0, bus.byteenable2}, {28'h0, e.be});
        chk("wr_data", bus.writedata2, e.data);
        chk("wr_offset", 32'(cyc - last_rd), 32'(e.off));
        chk("wr_busy", {31'h0, busy}, 32'h1);
      end
    end
    if (irq) begin
      irq_seen++;
      if (irq_q.size() == 0) begin
        chk("unexpected_irq", 32'h1, 32'h0);
      end else begin
        int o;
        o = irq_q.pop_front();
        chk("irq_offset", 32'(cyc - last_rd), 32'(o));
        chk("irq_busy_low", {31'h0, busy}, 32'h0);
      end
    end
  end

  task automatic hps_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    #1;
    hps_addr = a;
    hps_data = d;
    hps_we   = 1'b1;
    @(posedge clk);
    #1;
    hps_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cs"}, {31'h0, bus.chipselect2}, 32'h0);
    chk({tag, "_wr"}, {31'h0, bus.write2}, 32'h0);
    chk({tag, "_busy_irq"}, {30'h0, busy, irq}, 32'h0);
    chk({tag, "_addr"}, {30'h0, bus.address2}, 32'h0);
    chk({tag, "_be"}, {28'h0, bus.byteenable2}, 32'hF);
    chk({tag, "_wdata"}, bus.writedata2, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_clken", {31'h0, bus.clken2}, 32'h1);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_irq(input string tag);
    int start;
    start = irq_seen;
    for (int i = 0; i < 100 && irq_seen == start; i++) @(negedge clk);
    chk({tag, "_irq_timeout"}, {31'h0, irq_seen != start}, 32'h1);
    repeat (2) @(negedge clk);
  endtask

  task automatic push_expect(input logic [3:0] op, input bit legal, input logic [31:0] res,
                             input logic [7:0] seq, output logic [31:0] stat);
    stat = {12'h000, op, seq, 6'h00, ~legal, 1'b1};
    if (legal) exp_q.push_back('{2'd2, 4'hF, res, 5});
    exp_q.push_back('{2'd3, 4'hF, stat, legal ? 6 : 5});
    exp_q.push_back('{2'd0, 4'b1000, 32'h0, legal ? 7 : 6});
    irq_q.push_back(legal ? 8 : 7);
  endtask

  task automatic check_mem(input string tag, input logic [3:0] op, input bit legal,
                           input logic [31:0] res, input logic [31:0] b, input logic [31:0] stat);
    chk({tag, "_word2"}, mem[2], legal ? res : b);
    chk({tag, "_word3"}, mem[3], stat);
    chk({tag, "_word0"}, mem[0], {28'h0, op});
    chk({tag, "_queue_empty"}, 32'(exp_q.size() + irq_q.size()), 32'h0);
  endtask

  task automatic run_cmd(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input bit legal, input logic [31:0] res,
                         input logic [7:0] seq);
    logic [31:0] stat;
    hps_write(2'd1, a);
    hps_write(2'd2, b);
    push_expect(op, legal, res, seq, stat);
    hps_write(2'd0, {1'b1, 27'h0, op});
    wait_irq(tag);
    check_mem(tag, op, legal, res, b, stat);
  endtask

  initial begin
    logic [31:0] stat;
    bit          seen;

    do_reset();

    check_poll = 1;
    repeat (40) @(negedge clk);
    check_poll = 0;
    chk("idle_no_writes", 32'(mem[2] | mem[3] | mem[0]), 32'h0);

    run_cmd("add_wrap", 32'hFFFF_FFFF, 32'h0000_0002, 4'd0, 1'b1, 32'h0000_0001, 8'd1);

    do_reset();
    run_cmd("sub", 32'd5, 32'd7, 4'd1, 1'b1, 32'hFFFF_FFFE, 8'd1);
    run_cmd("xor", 32'hF0F0_F0F0, 32'hFFFF_0000, 4'd4, 1'b1, 32'h0F0F_F0F0, 8'd2);
    run_cmd("illegal", 32'h1234_5678, 32'hCAFE_BABE, 4'hF, 1'b0, 32'h0, 8'd3);
`ifdef MAILBOX_MUL_EN
    run_cmd("mul", 32'h0001_0001, 32'h0000_FFFF, 4'd5, 1'b1, 32'hFFFF_FFFF, 8'd4);
`else
    run_cmd("mul", 32'h0001_0001, 32'h0000_FFFF, 4'd5, 1'b0, 32'h0, 8'd4);
`endif

    // Reset while the engine is reading operand B; the command must rerun from scratch.
    do_reset();
    hps_write(2'd1, 32'hFF00_FF00);
    hps_write(2'd2, 32'h0F0F_0F0F);
    hps_write(2'd0, 32'h8000_0002);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.chipselect2 && !bus.write2 && bus.address2 == 2'd2;
    end
    chk("midreset_rd_b_timeout", {31'h0, seen}, 32'h1);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    chk("midreset_go_kept", mem[0], 32'h8000_0002);
    chk("midreset_word2_kept", mem[2], 32'h0F0F_0F0F);
    push_expect(4'd2, 1'b1, 32'h0F00_0F00, 8'd1, stat);
    #1;
    reset_n = 1'b1;
    wait_irq("midreset");
    check_mem("midreset", 4'd2, 1'b1, 32'h0F00_0F00, 32'h0F0F_0F0F, stat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
